// File: rtl/pipe_stage_elastic_pkg.sv
// rtl/pipe_stage_elastic_pkg.sv - shared types and width helper for the elastic pipeline chain
package pipe_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_BUSY,
        SLOT_FULL
    } slot_state_t;

    // Occupancy counter width sized for the skid build so both builds share one port width.
    function automatic int occ_width(input int stages);
        return $clog2(stages * 2 + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready/data handshake bundle with master/slave views
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic_slot.sv
// rtl/pipe_stage_elastic_slot.sv - one elastic slot; PIPE_SKID_EN selects a 2-entry skid slot
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

`ifdef PIPE_SKID_EN
    slot_state_t      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    // Ready depends only on registered state, breaking the ready chain at every slot.
    assign in_ready_o  = (state_q != SLOT_FULL);
    assign out_valid_o = (state_q != SLOT_EMPTY);
    assign out_data_o  = main_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign count_o     = (state_q == SLOT_FULL) ? 2'd2 :
                         (state_q == SLOT_BUSY) ? 2'd1 : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            main_q  <= INIT_VALUE;
            skid_q  <= INIT_VALUE;
        end else if (flush) begin
            state_q <= SLOT_EMPTY;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (push) begin
                        main_q  <= in_data_i;
                        state_q <= SLOT_BUSY;
                    end
                end
                SLOT_BUSY: begin
                    if (push && pop) begin
                        main_q <= in_data_i;
                    end else if (push) begin
                        skid_q  <= in_data_i;
                        state_q <= SLOT_FULL;
                    end else if (pop) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (pop) begin
                        main_q  <= skid_q;
                        state_q <= SLOT_BUSY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end
`else
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             push;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign push        = in_valid_i && in_ready_o;
    assign count_o     = {1'b0, valid_q};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= INIT_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
`endif

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - STAGES-deep elastic register chain; PIPE_SKID_EN enables skid slots
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               STAGES     = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    pipe_stage_elastic_if.slave              in_if,
    pipe_stage_elastic_if.master             out_if,
    output logic [occ_width(STAGES)-1:0]     occupancy
);

    localparam int OCC_W = occ_width(STAGES);

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] dat [STAGES+1];
    logic [1:0]       cnt [STAGES];
    logic [OCC_W-1:0] occ_d;

    assign vld[0]      = in_if.valid;
    assign dat[0]      = in_if.data;
    assign rdy[STAGES] = out_if.ready;

    // Producer sees no ready while reset is held, so nothing is accepted then.
    assign in_if.ready  = rdy[0] && !reset;
    assign out_if.valid = vld[STAGES];
    assign out_if.data  = dat[STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
        pipe_slot #(
            .WIDTH      (WIDTH),
            .INIT_VALUE (INIT_VALUE)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .in_valid_i  (vld[gi]),
            .in_ready_o  (rdy[gi]),
            .in_data_i   (dat[gi]),
            .out_valid_o (vld[gi+1]),
            .out_ready_i (rdy[gi+1]),
            .out_data_o  (dat[gi+1]),
            .count_o     (cnt[gi])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(cnt[i]);
        end
    end

    assign occupancy = occ_d;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed and random checks of pipe_stage_elastic (STAGES=3 and STAGES=2)
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

`ifdef PIPE_SKID_EN
    localparam int CAP2 = 4;
`else
    localparam int CAP2 = 2;
`endif
    localparam logic [31:0] INIT2 = 32'h5A5A;

    logic clk = 1'b0;
    logic rst3, rst2, fl3, fl2;
    logic [2:0] occ3, occ2;
    int tests = 0;
    int failed = 0;

    pipe_stage_elastic_if #(.WIDTH(32)) a_in ();
    pipe_stage_elastic_if #(.WIDTH(32)) a_out ();
    pipe_stage_elastic_if #(.WIDTH(32)) b_in ();
    pipe_stage_elastic_if #(.WIDTH(32)) b_out ();

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(32), .STAGES(3), .INIT_VALUE(32'h0)) dut3 (
        .clk(clk), .reset(rst3), .flush(fl3),
        .in_if(a_in), .out_if(a_out), .occupancy(occ3)
    );

    pipe_stage_elastic #(.WIDTH(32), .STAGES(2), .INIT_VALUE(INIT2)) dut2 (
        .clk(clk), .reset(rst2), .flush(fl2),
        .in_if(b_in), .out_if(b_out), .occupancy(occ2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc, nin, nout, first, acc0, cnt, bad;
        logic [31:0] sb[$];
        logic hold;

        rst3 = 1'b1; rst2 = 1'b1; fl3 = 1'b0; fl2 = 1'b0;
        a_in.valid = 1'b1; a_in.data = 32'hDEAD; a_out.ready = 1'b1;
        b_in.valid = 1'b1; b_in.data = 32'hBEEF; b_out.ready = 1'b1;
        tick(); tick();
        check("rst_in_ready3", {31'b0, a_in.ready}, 32'd0);
        check("rst_out_valid3", {31'b0, a_out.valid}, 32'd0);
        check("rst_occ3", {29'b0, occ3}, 32'd0);
        check("rst_out_data3", a_out.data, 32'h0);
        check("rst_out_data2", b_out.data, INIT2);
        check("rst_occ2", {29'b0, occ2}, 32'd0);
        a_in.valid = 1'b0; b_in.valid = 1'b0;
        rst3 = 1'b0; rst2 = 1'b0;
        tick();

        // Test 1: latency and order through three stages
        nin = 0; nout = 0; first = -1; acc0 = -1;
        a_out.ready = 1'b1;
        for (cyc = 0; cyc < 40 && nout < 8; cyc++) begin
            a_in.valid = (nin < 8);
            a_in.data  = 32'(nin + 1);
            #1;
            if (a_out.valid) begin
                if (first < 0) first = cyc;
                check("t1_order", a_out.data, 32'(nout + 1));
                nout++;
            end
            if (a_in.valid && a_in.ready) begin
                if (acc0 < 0) acc0 = cyc;
                nin++;
            end
            tick();
        end
        a_in.valid = 1'b0;
        check("t1_count", 32'(nout), 32'd8);
        check("t1_latency", 32'(first - acc0), 32'd3);

        // Test 2: fill with back-pressure, then drain
        b_out.ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            b_in.valid = 1'b1;
            b_in.data  = 32'h10 + 32'(cnt);
            #1;
            if (b_in.ready) cnt++;
            tick();
        end
        b_in.valid = 1'b0;
        #1;
        check("t2_accepts", 32'(cnt), 32'(CAP2));
        check("t2_occ_full", {29'b0, occ2}, 32'(CAP2));
        check("t2_in_ready_full", {31'b0, b_in.ready}, 32'd0);
        check("t2_head", b_out.data, 32'h10);
        // Test 6: ready path from the consumer side
        b_out.ready = 1'b1;
        #1;
`ifdef PIPE_SKID_EN
        check("t6_no_comb_ready", {31'b0, b_in.ready}, 32'd0);
`else
        check("t6_comb_ready", {31'b0, b_in.ready}, 32'd1);
`endif
        nout = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_out.valid) begin
                check("t2_drain", b_out.data, 32'h10 + 32'(nout));
                nout++;
            end
            tick();
        end
        check("t2_drain_count", 32'(nout), 32'(CAP2));
        check("t2_occ_empty", {29'b0, occ2}, 32'd0);

        // Test 4: flush a full chain while offering 0xAA
        b_out.ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            b_in.valid = 1'b1;
            b_in.data  = 32'h20 + 32'(cnt);
            #1;
            if (b_in.ready) cnt++;
            tick();
        end
        b_out.ready = 1'b1; b_in.valid = 1'b1; b_in.data = 32'hAA; fl2 = 1'b1;
        tick();
        fl2 = 1'b0; b_in.valid = 1'b0;
        #1;
        check("t4_out_valid", {31'b0, b_out.valid}, 32'd0);
        check("t4_occ", {29'b0, occ2}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (b_out.valid) cnt++;
            tick();
        end
        check("t4_no_emit", 32'(cnt), 32'd0);

        // Test 5: reset with two words in flight
        b_out.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b_in.valid = 1'b1;
            b_in.data  = 32'h30 + 32'(i);
            tick();
        end
        b_in.valid = 1'b0;
        #1;
        check("t5_occ_before", {29'b0, occ2}, 32'd2);
        rst2 = 1'b1; b_out.ready = 1'b1; b_in.valid = 1'b1; b_in.data = 32'h77;
        #1;
        check("t5_in_ready_rst", {31'b0, b_in.ready}, 32'd0);
        tick();
        check("t5_out_valid", {31'b0, b_out.valid}, 32'd0);
        check("t5_out_data", b_out.data, INIT2);
        check("t5_occ", {29'b0, occ2}, 32'd0);
        check("t5_in_ready_rst2", {31'b0, b_in.ready}, 32'd0);
        rst2 = 1'b0; b_in.valid = 1'b0;
        #1;
        check("t5_in_ready_after", {31'b0, b_in.ready}, 32'd1);

        // Test 3: random traffic with scoreboard
        nin = 0; nout = 0; hold = 1'b0; bad = 0;
        for (cyc = 0; cyc < 60000 && nout < 10000; cyc++) begin
            if (!hold && nin < 10000) begin
                hold = ($urandom_range(1, 0) == 1);
                a_in.data = $urandom;
            end
            a_in.valid  = hold;
            a_out.ready = ($urandom_range(1, 0) == 1);
            #1;
            if (a_out.valid && a_out.ready) begin
                if (sb.size() == 0) begin
                    check("t3_unexpected", a_out.data, 32'hFFFF_FFFF);
                end else begin
                    if (a_out.data !== sb[0]) begin
                        check("t3_data", a_out.data, sb[0]);
                        bad++;
                    end
                    void'(sb.pop_front());
                end
                nout++;
            end
            if (a_in.valid && a_in.ready) begin
                sb.push_back(a_in.data);
                nin++;
                hold = 1'b0;
            end
            if (32'(occ3) > 32'd6) bad++;
            tick();
        end
        a_in.valid = 1'b0;
        check("t3_received", 32'(nout), 32'd10000);
        check("t3_leftover", 32'(sb.size()), 32'd0);
        check("t3_errors", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
